// File: rtl/vga_timing_monitor.sv
// VGA timing monitor: measures line/frame timing of a VGA stream sampled
// on CLOCK_50, locks onto stable timing and captures one probed pixel.
module vga_timing_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        VGA_CLK,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        VGA_BLANK_N,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B,
    input  logic [9:0]  PROBE_X,
    input  logic [9:0]  PROBE_Y,
    input  logic        ERR_CLR,
    output logic        LOCKED,
    output logic        SYNC_ERR,
    output logic [9:0]  LINE_LEN,
    output logic [9:0]  FRAME_LINES,
    output logic [15:0] FRAME_COUNT,
    output logic [23:0] PROBE_RGB,
    output logic        PROBE_VALID
);
    localparam logic [11:0] HT  = 12'(H_TOTAL);
    localparam logic [11:0] HT2 = 12'(2 * H_TOTAL);
    localparam logic [9:0]  HA  = 10'(H_ACTIVE);
    localparam logic [9:0]  VT  = 10'(V_TOTAL);
    localparam logic [9:0]  VA  = 10'(V_ACTIVE);
    localparam logic [7:0]  LF  = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCK} state_e;

    state_e      state_q, state_d;
    logic        vclk_q, hs_q, hs_d, vs_q, vs_d;
    logic [6:0]  idle_q, idle_d;
    logic [11:0] line_cnt_q, line_cnt_d;
    logic [9:0]  col_q, col_d, act_q, act_d, lines_q, lines_d;
    logic        lerr_q, lerr_d;
    logic [7:0]  gcnt_q, gcnt_d;
    logic        locked_q, locked_d, err_q, err_d;
    logic [9:0]  len_q, len_d, flines_q, flines_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        pend_q, pend_d, pvalid_q, pvalid_d;
    logic [23:0] pend_rgb_q, pend_rgb_d, rgb_q, rgb_d;

    logic        tick, clk_edge, lclose, fclose, line_act, lerr_now;
    logic        good, cap, timeout, set_err;
    logic [9:0]  nlines, nact, cur_col, cur_row;

    assign tick     = VGA_CLK & ~vclk_q;
    assign clk_edge = VGA_CLK ^ vclk_q;
    assign lclose   = tick & hs_q & ~VGA_HS;
    assign fclose   = tick & vs_q & ~VGA_VS;
    assign line_act = (col_q != '0);
    assign lerr_now = (line_cnt_q != HT) || (line_act && (col_q != HA));
    // A line closing on the frame-close tick is counted into the old frame
    assign nlines   = lines_q + 10'(lclose);
    assign nact     = act_q + 10'(lclose & line_act);
    assign good     = (nlines == VT) && (nact == VA) && !lerr_q
                      && !(lclose && lerr_now);
    assign cur_col  = lclose ? '0 : col_q;
    assign cur_row  = fclose ? '0 : nact;
    assign cap      = tick & VGA_BLANK_N & (cur_col == PROBE_X)
                      & (cur_row == PROBE_Y);
    assign timeout  = idle_q[6] | (line_cnt_q >= HT2);

    always_comb begin
        hs_d        = hs_q;
        vs_d        = vs_q;
        idle_d      = idle_q;
        line_cnt_d  = line_cnt_q;
        col_d       = col_q;
        act_d       = act_q;
        lines_d     = lines_q;
        lerr_d      = lerr_q;
        len_d       = len_q;
        flines_d    = flines_q;
        frame_cnt_d = frame_cnt_q;
        pend_d      = pend_q;
        pend_rgb_d  = pend_rgb_q;
        rgb_d       = rgb_q;
        pvalid_d    = 1'b0;
        state_d     = state_q;
        gcnt_d      = gcnt_q;
        set_err     = 1'b0;

        if (clk_edge) begin
            idle_d = '0;
        end else if (!idle_q[6]) begin
            idle_d = idle_q + 7'd1;
        end

        if (tick) begin
            hs_d = VGA_HS;
            vs_d = VGA_VS;
            if (line_cnt_q != '1) line_cnt_d = line_cnt_q + 12'd1;
            if (VGA_BLANK_N) col_d = col_q + 10'd1;
            if (lclose) begin
                line_cnt_d = 12'd1;
                col_d      = {9'd0, VGA_BLANK_N};
                len_d      = line_cnt_q[9:0];
                lines_d    = nlines;
                act_d      = nact;
                lerr_d     = lerr_q | lerr_now;
            end
            if (fclose) begin
                lines_d  = '0;
                act_d    = '0;
                lerr_d   = 1'b0;
                flines_d = nlines;
                if (state_q != SEARCH) frame_cnt_d = frame_cnt_q + 16'd1;
                if (pend_q) begin
                    rgb_d    = pend_rgb_q;
                    pvalid_d = 1'b1;
                end
                pend_d = 1'b0;
            end
            if (cap) begin
                pend_d     = 1'b1;
                pend_rgb_d = {VGA_R, VGA_G, VGA_B};
            end
        end

        unique case (state_q)
            SEARCH: begin
                if (fclose) begin
                    state_d = MEASURE;
                    gcnt_d  = '0;
                end
            end
            MEASURE: begin
                if (fclose) begin
                    if (good) begin
                        gcnt_d = gcnt_q + 8'd1;
                        if (gcnt_q + 8'd1 >= LF) state_d = LOCK;
                    end else begin
                        gcnt_d = '0;
                    end
                end
            end
            LOCK: begin
                if ((lclose && lerr_now) || (fclose && !good)) begin
                    state_d = MEASURE;
                    gcnt_d  = '0;
                    set_err = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase

        if (timeout) begin
            state_d = SEARCH;
            gcnt_d  = '0;
            if (state_q == LOCK) set_err = 1'b1;
        end

        err_d = set_err ? 1'b1 : (ERR_CLR ? 1'b0 : err_q);
        locked_d = (state_d == LOCK);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q     <= SEARCH;
            vclk_q      <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            idle_q      <= '0;
            line_cnt_q  <= '0;
            col_q       <= '0;
            act_q       <= '0;
            lines_q     <= '0;
            lerr_q      <= 1'b0;
            gcnt_q      <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            len_q       <= '0;
            flines_q    <= '0;
            frame_cnt_q <= '0;
            pend_q      <= 1'b0;
            pend_rgb_q  <= '0;
            rgb_q       <= '0;
            pvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            vclk_q      <= VGA_CLK;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            idle_q      <= idle_d;
            line_cnt_q  <= line_cnt_d;
            col_q       <= col_d;
            act_q       <= act_d;
            lines_q     <= lines_d;
            lerr_q      <= lerr_d;
            gcnt_q      <= gcnt_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            len_q       <= len_d;
            flines_q    <= flines_d;
            frame_cnt_q <= frame_cnt_d;
            pend_q      <= pend_d;
            pend_rgb_q  <= pend_rgb_d;
            rgb_q       <= rgb_d;
            pvalid_q    <= pvalid_d;
        end
    end

    assign LOCKED      = locked_q;
    assign SYNC_ERR    = err_q;
    assign LINE_LEN    = len_q;
    assign FRAME_LINES = flines_q;
    assign FRAME_COUNT = frame_cnt_q;
    assign PROBE_RGB   = rgb_q;
    assign PROBE_VALID = pvalid_q;
endmodule
